// File: rtl/mem_bus_responder.sv
// Memory-bus responder: 256x16 RAM, LED register and synchronized switches behind a wait-state FSM.
// Optional access counters at 0x180/0x181 are enabled by defining MEM_BUS_ACCESS_COUNT_EN.
module mem_bus_responder #(
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = "data.txt"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  sw_in,
    output logic        mem_ready,
    output logic [15:0] read_data,
    output logic [7:0]  led_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [3:0] WS_LOAD   = WAIT_STATES[3:0];

    localparam logic [8:0] ADDR_LED  = 9'h100;
    localparam logic [8:0] ADDR_SW   = 9'h140;
`ifdef MEM_BUS_ACCESS_COUNT_EN
    localparam logic [8:0] ADDR_RDC  = 9'h180;
    localparam logic [8:0] ADDR_WRC  = 9'h181;
`endif

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [3:0]  r_cnt;
    logic [1:0]  r_cmd;
    logic [8:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_mem [0:255];
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [15:0] r_read_data;
    logic [7:0]  r_led;
    logic        r_bus_err;
    logic        r_mem_ready;
    logic [15:0] w_rd_value;
    logic        w_unmapped;
    logic        w_do_read;
    logic        w_do_write;
`ifdef MEM_BUS_ACCESS_COUNT_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
`endif

    // Next-state logic and command acceptance.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE)) begin
                    w_accept = 1'b1;
                    w_next   = (WS_LOAD != 4'd0) ? S_WAIT : S_RESP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, command capture, wait counter and ready strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cmd       <= 2'b00;
            r_addr      <= 9'd0;
            r_wdata     <= 16'd0;
            r_mem_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mem_ready <= (w_next == S_RESP);
            if (w_accept) begin
                r_cmd   <= mem_cmd;
                r_addr  <= mem_addr;
                r_wdata <= write_data;
                r_cnt   <= WS_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Address decode of the captured access.
    always_comb begin
        w_rd_value = 16'h0000;
        w_unmapped = 1'b0;
        if (!r_addr[8]) begin
            w_rd_value = r_mem[r_addr[7:0]];
        end else if (r_addr == ADDR_LED) begin
            w_rd_value = {8'h00, r_led};
        end else if (r_addr == ADDR_SW) begin
            w_rd_value = {8'h00, r_sw_sync};
`ifdef MEM_BUS_ACCESS_COUNT_EN
        end else if (r_addr == ADDR_RDC) begin
            w_rd_value = r_rd_count;
        end else if (r_addr == ADDR_WRC) begin
            w_rd_value = r_wr_count;
`endif
        end else begin
            w_rd_value = 16'h0000;
            w_unmapped = 1'b1;
        end
    end

    assign w_do_read  = (r_state == S_RESP) && (r_cmd == CMD_READ);
    assign w_do_write = (r_state == S_RESP) && (r_cmd == CMD_WRITE);

    // Two-flop synchronizer for the board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Response-edge side effects: read data, LED register, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= 16'h0000;
            r_led       <= 8'h00;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_do_read) begin
                r_read_data <= w_rd_value;
            end else begin
                r_read_data <= r_read_data;
            end
            if (w_do_write && (r_addr == ADDR_LED)) begin
                r_led <= r_wdata[7:0];
            end else begin
                r_led <= r_led;
            end
            if ((w_do_read || w_do_write) && w_unmapped) begin
                r_bus_err <= 1'b1;
            end else begin
                r_bus_err <= r_bus_err;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write && !r_addr[8]) begin
            r_mem[r_addr[7:0]] <= r_wdata;
        end
    end

`ifdef MEM_BUS_ACCESS_COUNT_EN
    // Saturating completed-access counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            if (w_do_read && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end else begin
                r_rd_count <= r_rd_count;
            end
            if (w_do_write && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end else begin
                r_wr_count <= r_wr_count;
            end
        end
    end
`endif

    assign mem_ready = r_mem_ready;
    assign read_data = r_read_data;
    assign led_out   = r_led;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with 3 wait states, one with none, checked against a
// behavioural address-map model.
module tb_mem_bus_responder;

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic [7:0]  sw_in = 8'h00;
    logic [1:0]  cmd_a = 2'b00, cmd_b = 2'b00;
    logic [8:0]  addr_a = 9'd0, addr_b = 9'd0;
    logic [15:0] wd_a = 16'd0, wd_b = 16'd0;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [15:0] rd_a, rd_b;
    logic [7:0]  led_a, led_b;

    mem_bus_responder #(.WAIT_STATES(3), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset), .mem_cmd(cmd_a), .mem_addr(addr_a), .write_data(wd_a),
        .sw_in(sw_in), .mem_ready(rdy_a), .read_data(rd_a), .led_out(led_a), .bus_err(err_a));

    mem_bus_responder #(.WAIT_STATES(0), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset), .mem_cmd(cmd_b), .mem_addr(addr_b), .write_data(wd_b),
        .sw_in(sw_in), .mem_ready(rdy_b), .read_data(rd_b), .led_out(led_b), .bus_err(err_b));

    int total = 0;
    int bad   = 0;

    // Reference state per instance (0 = dut_a, 1 = dut_b).
    logic [15:0] m_mem [2][256];
    bit          m_val [2][256];
    logic [7:0]  m_led [2];
    bit          m_err [2];
    logic [15:0] m_rd  [2];
    int          m_rc  [2];
    int          m_wc  [2];
    logic [7:0]  sw_cur = 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
        if (d == 0) begin
            cmd_a = c; addr_a = a; wd_a = w;
        end else begin
            cmd_b = c; addr_b = a; wd_b = w;
        end
    endtask

    function automatic logic [15:0] obs(input int d, input int sel);
        case (sel)
            0:       return (d == 0) ? {15'd0, rdy_a} : {15'd0, rdy_b};
            1:       return (d == 0) ? rd_a : rd_b;
            2:       return (d == 0) ? {8'h00, led_a} : {8'h00, led_b};
            default: return (d == 0) ? {15'd0, err_a} : {15'd0, err_b};
        endcase
    endfunction

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 8'h00; m_err[d] = 1'b0; m_rd[d] = 16'h0000;
            m_rc[d] = 0; m_wc[d] = 0;
        end
    endtask

    task automatic set_sw(input logic [7:0] v);
        @(negedge clk);
        sw_in = v;
        repeat (3) @(negedge clk);
        sw_cur = v;
    endtask

    // One complete bus transaction, CPU-style: hold the command until mem_ready is seen.
    task automatic access(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
        int          ws;
        logic [15:0] exp_rd;
        bit          e;
        ws     = (d == 0) ? 3 : 0;
        exp_rd = m_rd[d];
        e      = 1'b0;
        if (!a[8]) begin
            if (c == RD) exp_rd = m_mem[d][a[7:0]];
            else begin m_mem[d][a[7:0]] = w; m_val[d][a[7:0]] = 1'b1; end
        end else if (a == 9'h100) begin
            if (c == RD) exp_rd = {8'h00, m_led[d]};
            else m_led[d] = w[7:0];
        end else if (a == 9'h140) begin
            if (c == RD) exp_rd = {8'h00, sw_cur};
`ifdef MEM_BUS_ACCESS_COUNT_EN
        end else if (a == 9'h180) begin
            if (c == RD) exp_rd = sat16(m_rc[d]);
        end else if (a == 9'h181) begin
            if (c == RD) exp_rd = sat16(m_wc[d]);
`endif
        end else begin
            if (c == RD) exp_rd = 16'h0000;
            e = 1'b1;
        end
        if (c == RD) begin m_rd[d] = exp_rd; m_rc[d]++; end
        else m_wc[d]++;
        m_err[d] = m_err[d] | e;

        @(negedge clk);
        drive(d, c, a, w);
        for (int i = 1; i <= ws + 1; i++) begin
            @(negedge clk);
            if (i <= ws) begin
                chk($sformatf("rdy_wait%0d", i), obs(d, 0), 16'd0);
                drive(d, c, 9'($urandom), 16'($urandom));
            end else begin
                chk("rdy_pulse", obs(d, 0), 16'd1);
                drive(d, 2'b00, 9'($urandom), 16'($urandom));
            end
        end
        @(negedge clk);
        chk("rdy_once", obs(d, 0), 16'd0);
        chk("rdata", obs(d, 1), m_rd[d]);
        chk("led", obs(d, 2), {8'h00, m_led[d]});
        chk("err", obs(d, 3), {15'd0, m_err[d]});
    endtask

    task automatic random_ops(input int d, input int n);
        int          r;
        logic [7:0]  ra;
        logic [8:0]  a;
        for (int k = 0; k < n; k++) begin
            r  = $urandom_range(0, 8);
            ra = 8'($urandom);
            a  = {1'b0, ra};
            case (r)
                0, 1: begin
                    if (m_val[d][ra]) access(d, RD, a, 16'($urandom));
                    else access(d, WR, a, 16'($urandom));
                end
                2, 3: access(d, WR, a, 16'($urandom));
                4:    access(d, WR, 9'h100, 16'($urandom));
                5:    access(d, RD, 9'h100, 16'($urandom));
                6:    access(d, RD, 9'h140, 16'($urandom));
                7:    access(d, WR, 9'h140, 16'($urandom));
                default: begin
                    set_sw(8'($urandom));
                    access(d, RD, 9'h140, 16'($urandom));
                end
            endcase
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) begin m_mem[d][i] = 16'h0000; m_val[d][i] = 1'b0; end
        reset_model();

        #2 reset = 1'b1;
        #10;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", obs(d, 0), 16'd0);
            chk("rst_rdata", obs(d, 1), 16'd0);
            chk("rst_led", obs(d, 2), 16'd0);
            chk("rst_err", obs(d, 3), 16'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait instance: single-cycle latency.
        access(1, WR, 9'h003, 16'h0007);
        access(1, RD, 9'h003, 16'h0000);
        access(1, RD, 9'h003, 16'h0000);

        // Three-wait instance directed cases.
        access(0, WR, 9'h010, 16'hBEEF);
        access(0, RD, 9'h010, 16'h0000);
        access(0, WR, 9'h100, 16'h12A5);
        access(0, RD, 9'h100, 16'h0000);
        set_sw(8'h3C);
        access(0, RD, 9'h140, 16'h0000);
        access(0, WR, 9'h140, 16'h5555);

        random_ops(0, 40);
        random_ops(1, 15);

        // Counter window (unmapped when the counters are absent).
        access(0, RD, 9'h180, 16'h0000);
        access(0, RD, 9'h181, 16'h0000);
        access(0, WR, 9'h180, 16'hFFFF);
        access(0, RD, 9'h1FF, 16'h0000);
        access(0, WR, 9'h1C3, 16'h1234);
        access(0, WR, 9'h010, 16'hCAFE);
        access(0, RD, 9'h010, 16'h0000);
        access(1, RD, 9'h1FF, 16'h0000);
        access(1, RD, 9'h003, 16'h0000);

        // Reset asserted in the middle of a RAM write's wait phase.
        @(negedge clk);
        drive(0, WR, 9'h010, 16'h1234);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rdy", obs(0, 0), 16'd0);
        chk("midrst_rdata", obs(0, 1), 16'd0);
        chk("midrst_led", obs(0, 2), 16'd0);
        chk("midrst_err", obs(0, 3), 16'd0);
        drive(0, 2'b00, 9'd0, 16'd0);
        reset_model();
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_rdy", obs(0, 0), 16'd0);
        end
        access(0, RD, 9'h010, 16'h0000);
        access(1, RD, 9'h003, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
